pnr_signal_router: RTL and testbench
====================================

PNR_SIGNAL_ROUTER -- requirements
Module: pnr_signal_router

Interface
REQ-001 SHALL have parameter DW, default 14: ADC sample width, signed two's complement.
REQ-002 SHALL have parameter NCH, default 2, legal 2..8: number of ADC input channels.
REQ-003 SHALL have parameter BW, default 8: blanking counter width.
REQ-004 SHALL have port clk_i, input, 1: ADC sample clock; the only clock in the block.
REQ-005 SHALL have port rstn_i, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port adc_dat_i, input, NCH*DW: packed channel samples; channel k occupies bits [k*DW +: DW].
REQ-007 SHALL have port trig_sel_i, input, SW = max(1, clog2(NCH)): requested trigger-source channel.
REQ-008 SHALL have port pnr_sel_i, input, SW: requested PNR-source channel.
REQ-009 SHALL have port sel_req_i, input, 1: single-cycle strobe requesting that the selections be applied.
REQ-010 SHALL have port busy_i, input, 1: downstream PNR detector is mid-pulse; switching is deferred while high.
REQ-011 SHALL have port blank_len_i, input, BW: number of blanked cycles after a switch.
REQ-012 SHALL have port trig_sig_o, output, DW: routed trigger signal.
REQ-013 SHALL have port pnr_sig_o, output, DW: routed PNR signal.
REQ-014 SHALL have port sig_valid_o, output, 1: outputs carry valid routed data.
REQ-015 SHALL have port trig_act_o, output, SW: trigger selection currently in force.
REQ-016 SHALL have port pnr_act_o, output, SW: PNR selection currently in force.
REQ-017 SHALL have port sel_ack_o, output, 1: one-cycle pulse when a request completes.
REQ-018 SHALL have port sel_err_o, output, 1: one-cycle pulse when a request is rejected.

Function
REQ-019 SHALL register both outputs: trig_sig_o and pnr_sig_o equal the selected channels' adc_dat_i delayed by exactly 1 cycle (without the REQ-031 offset feature).
REQ-020 SHALL implement an FSM with states RUN, PEND and BLANK.
REQ-021 SHALL, in RUN, accept sel_req_i: if either requested index is >= NCH, pulse sel_err_o on the next cycle, stay in RUN and keep the active selections; otherwise latch both requested indices.
REQ-022 SHALL, after a valid request is latched in RUN, go to PEND if busy_i is high that cycle; otherwise apply the latched selection immediately.
REQ-023 SHALL, in PEND, apply the latched selection on the first cycle busy_i is low.
REQ-024 SHALL, on apply, update trig_act_o and pnr_act_o, load the counter with blank_len_i, and go to BLANK; if blank_len_i = 0, go directly to RUN and pulse sel_ack_o on the next cycle.
REQ-025 SHALL, in BLANK, drive sig_valid_o = 0 and both outputs = 0; decrement the counter each cycle; on reaching 0, enter RUN and pulse sel_ack_o.
REQ-026 SHALL ignore sel_req_i in PEND and BLANK: no ack, no error, no effect.
REQ-027 SHALL allow trig and pnr to select the same channel; this is legal.
REQ-028 SHALL drive sig_valid_o = 1 in RUN and PEND, from the second cycle after reset release onward.

Reset
REQ-029 SHALL, while rstn_i = 0 at a clk_i edge: set state to RUN, trig_act_o = 0, pnr_act_o = 1, both outputs = 0, and sig_valid_o, sel_ack_o, sel_err_o = 0.
REQ-030 SHALL abandon any PEND or BLANK state on reset mid-operation, with no ack issued.

Configuration
REQ-031 SHALL, when macro PNR_ROUTER_OFFSET_EN is defined, add inputs trig_ofs_i and pnr_ofs_i (signed, DW) and add one more pipeline stage: each output = saturated (sample - offset), clamped to [-2^(DW-1), 2^(DW-1)-1], for a 2-cycle total latency.
REQ-032 SHALL, when PNR_ROUTER_OFFSET_EN is undefined, have no offset ports and keep a 1-cycle latency.

Structure
REQ-033 SHALL place the FSM state enum and the reset defaults (TRIG_RST = 0, PNR_RST = 1) in shared package pnr_pkg.
REQ-034 SHALL implement the offset-and-saturate datapath as sub-module pnr_sat_sub (parameter DW), instantiated once per output under the macro.

Verification
REQ-035 SHALL cover reset, NCH=2: ch0 = 100 and ch1 = -50 constant -> after 2 cycles, trig_sig_o = 100, pnr_sig_o = -50, sig_valid_o = 1.
REQ-036 SHALL cover swap: sel_req_i with trig = 1, pnr = 0, blank_len = 3, busy low -> sig_valid_o low for exactly 3 cycles; sel_ack_o pulses; then trig_sig_o = -50.
REQ-037 SHALL cover deferral: busy_i held high for 10 cycles across a request -> actives unchanged until busy_i falls; ack follows blank_len + 1 cycles later.
REQ-038 SHALL cover rejection: NCH = 3, request trig = 3 -> sel_err_o pulses once; actives unchanged; no blanking.
REQ-039 SHALL cover ignored request: sel_req_i during BLANK -> no ack, no error, and selection per the first request only.
REQ-040 SHALL cover saturation (macro defined): sample 8000, offset -1000, DW = 14 -> output 8191 after 2 cycles.

Source files
------------

// File: rtl/pnr_pkg.sv
// rtl/pnr_pkg.sv - shared FSM state encoding and reset-time channel selections for the PNR router
package pnr_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PEND  = 2'd1,
    ST_BLANK = 2'd2
  } pnr_state_e;

  localparam int TRIG_RST = 0;
  localparam int PNR_RST  = 1;

endpackage

// File: rtl/pnr_sat_sub.sv
// rtl/pnr_sat_sub.sv - registered (sample - offset) with two's complement saturation to DW bits
module pnr_sat_sub #(
  parameter int DW = 14
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 blank_i,
  input  logic signed [DW-1:0] dat_i,
  input  logic signed [DW-1:0] ofs_i,
  output logic signed [DW-1:0] dat_o
);

  localparam logic signed [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};

  logic signed [DW:0] diff;

  // One guard bit: overflow shows up as the top two bits disagreeing.
  assign diff = {dat_i[DW-1], dat_i} - {ofs_i[DW-1], ofs_i};

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      dat_o <= '0;
    end else if (blank_i) begin
      dat_o <= '0;
    end else if (diff[DW] != diff[DW-1]) begin
      dat_o <= diff[DW] ? SMIN : SMAX;
    end else begin
      dat_o <= diff[DW-1:0];
    end
  end

endmodule

// File: rtl/pnr_signal_router.sv
// rtl/pnr_signal_router.sv - routes two ADC channels to trigger/PNR paths with deferred, blanked switching
// Optional PNR_ROUTER_OFFSET_EN adds per-output offset subtraction with saturation (one extra stage).
module pnr_signal_router
  import pnr_pkg::*;
#(
  parameter  int DW  = 14,
  parameter  int NCH = 2,
  parameter  int BW  = 8,
  localparam int SW  = (NCH > 2) ? $clog2(NCH) : 1
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [NCH*DW-1:0]    adc_dat_i,
  input  logic [SW-1:0]        trig_sel_i,
  input  logic [SW-1:0]        pnr_sel_i,
  input  logic                 sel_req_i,
  input  logic                 busy_i,
  input  logic [BW-1:0]        blank_len_i,
`ifdef PNR_ROUTER_OFFSET_EN
  input  logic signed [DW-1:0] trig_ofs_i,
  input  logic signed [DW-1:0] pnr_ofs_i,
`endif
  output logic signed [DW-1:0] trig_sig_o,
  output logic signed [DW-1:0] pnr_sig_o,
  output logic                 sig_valid_o,
  output logic [SW-1:0]        trig_act_o,
  output logic [SW-1:0]        pnr_act_o,
  output logic                 sel_ack_o,
  output logic                 sel_err_o
);

  localparam logic [SW:0] NCH_W = (SW+1)'(NCH);

  pnr_state_e           state;
  logic [BW-1:0]        cnt;
  logic [SW-1:0]        lat_trig, lat_pnr;
  logic                 sel_bad, apply_run, apply_pend, apply_go, blank_next;
  logic [SW-1:0]        new_trig, new_pnr;
  logic signed [DW-1:0] trig_raw, pnr_raw;
  logic signed [DW-1:0] trig_q, pnr_q;
  logic                 valid_q, warm;

  always_comb begin
    sel_bad    = ({1'b0, trig_sel_i} >= NCH_W) || ({1'b0, pnr_sel_i} >= NCH_W);
    apply_run  = (state == ST_RUN) && sel_req_i && !sel_bad && !busy_i;
    apply_pend = (state == ST_PEND) && !busy_i;
    apply_go   = apply_run || apply_pend;
    new_trig   = apply_pend ? lat_trig : trig_sel_i;
    new_pnr    = apply_pend ? lat_pnr  : pnr_sel_i;
    // Blanking is known one edge early so the output registers can zero in step with the FSM.
    blank_next = (apply_go && (blank_len_i != '0)) ||
                 ((state == ST_BLANK) && (cnt != BW'(1)));
  end

  always_comb begin
    trig_raw = '0;
    pnr_raw  = '0;
    for (int k = 0; k < NCH; k++) begin
      if (trig_act_o == SW'(k)) trig_raw = adc_dat_i[k*DW +: DW];
      if (pnr_act_o  == SW'(k)) pnr_raw  = adc_dat_i[k*DW +: DW];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state      <= ST_RUN;
      cnt        <= '0;
      lat_trig   <= SW'(TRIG_RST);
      lat_pnr    <= SW'(PNR_RST);
      trig_act_o <= SW'(TRIG_RST);
      pnr_act_o  <= SW'(PNR_RST);
      sel_ack_o  <= 1'b0;
      sel_err_o  <= 1'b0;
    end else begin
      sel_ack_o <= 1'b0;
      sel_err_o <= 1'b0;
      case (state)
        ST_RUN: begin
          if (sel_req_i) begin
            if (sel_bad) begin
              sel_err_o <= 1'b1;
            end else begin
              lat_trig <= trig_sel_i;
              lat_pnr  <= pnr_sel_i;
              if (busy_i) state <= ST_PEND;
            end
          end
        end
        ST_PEND: ;
        ST_BLANK: begin
          cnt <= cnt - BW'(1);
          if (cnt == BW'(1)) begin
            state     <= ST_RUN;
            sel_ack_o <= 1'b1;
          end
        end
        default: state <= ST_RUN;
      endcase
      if (apply_go) begin
        trig_act_o <= new_trig;
        pnr_act_o  <= new_pnr;
        cnt        <= blank_len_i;
        if (blank_len_i == '0) begin
          state     <= ST_RUN;
          sel_ack_o <= 1'b1;
        end else begin
          state <= ST_BLANK;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      trig_q  <= '0;
      pnr_q   <= '0;
      valid_q <= 1'b0;
      warm    <= 1'b0;
    end else begin
      warm    <= 1'b1;
      valid_q <= warm && !blank_next;
      trig_q  <= blank_next ? '0 : trig_raw;
      pnr_q   <= blank_next ? '0 : pnr_raw;
    end
  end

`ifdef PNR_ROUTER_OFFSET_EN
  logic blank_q;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      blank_q     <= 1'b0;
      sig_valid_o <= 1'b0;
    end else begin
      blank_q     <= blank_next;
      sig_valid_o <= valid_q;
    end
  end

  pnr_sat_sub #(.DW(DW)) u_trig_sat (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .blank_i (blank_q),
    .dat_i   (trig_q),
    .ofs_i   (trig_ofs_i),
    .dat_o   (trig_sig_o)
  );

  pnr_sat_sub #(.DW(DW)) u_pnr_sat (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .blank_i (blank_q),
    .dat_i   (pnr_q),
    .ofs_i   (pnr_ofs_i),
    .dat_o   (pnr_sig_o)
  );
`else
  assign trig_sig_o  = trig_q;
  assign pnr_sig_o   = pnr_q;
  assign sig_valid_o = valid_q;
`endif

endmodule

// File: tb/tb_pnr_signal_router.sv
// tb/tb_pnr_signal_router.sv - directed checks of routing, blanking, deferral, rejection and reset
module tb_pnr_signal_router;

  localparam int DW = 14;
  localparam int BW = 8;
`ifdef PNR_ROUTER_OFFSET_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;

  logic [2*DW-1:0]      adc2;
  logic                 tsel2, psel2, req2, busy2;
  logic [BW-1:0]        bl2;
  logic signed [DW-1:0] trig2, pnr2;
  logic                 vld2, tact2, pact2, ack2, err2;

  logic [3*DW-1:0]      adc3;
  logic [1:0]           tsel3, psel3, tact3, pact3;
  logic                 req3, busy3;
  logic [BW-1:0]        bl3;
  logic signed [DW-1:0] trig3, pnr3;
  logic                 vld3, ack3, err3;

`ifdef PNR_ROUTER_OFFSET_EN
  logic signed [DW-1:0] tofs2, pofs2, tofs3, pofs3;
`endif

  pnr_signal_router #(.DW(DW), .NCH(2), .BW(BW)) u_dut2 (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .adc_dat_i   (adc2),
    .trig_sel_i  (tsel2),
    .pnr_sel_i   (psel2),
    .sel_req_i   (req2),
    .busy_i      (busy2),
    .blank_len_i (bl2),
`ifdef PNR_ROUTER_OFFSET_EN
    .trig_ofs_i  (tofs2),
    .pnr_ofs_i   (pofs2),
`endif
    .trig_sig_o  (trig2),
    .pnr_sig_o   (pnr2),
    .sig_valid_o (vld2),
    .trig_act_o  (tact2),
    .pnr_act_o   (pact2),
    .sel_ack_o   (ack2),
    .sel_err_o   (err2)
  );

  pnr_signal_router #(.DW(DW), .NCH(3), .BW(BW)) u_dut3 (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .adc_dat_i   (adc3),
    .trig_sel_i  (tsel3),
    .pnr_sel_i   (psel3),
    .sel_req_i   (req3),
    .busy_i      (busy3),
    .blank_len_i (bl3),
`ifdef PNR_ROUTER_OFFSET_EN
    .trig_ofs_i  (tofs3),
    .pnr_ofs_i   (pofs3),
`endif
    .trig_sig_o  (trig3),
    .pnr_sig_o   (pnr3),
    .sig_valid_o (vld3),
    .trig_act_o  (tact3),
    .pnr_act_o   (pact3),
    .sel_ack_o   (ack3),
    .sel_err_o   (err3)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic drive2(input logic t, input logic p, input int bl);
    req2  = 1'b1;
    tsel2 = t;
    psel2 = p;
    bl2   = BW'(bl);
  endtask

  task automatic watch2(input int n, output int acks, output int errs, output int lows);
    acks = 0; errs = 0; lows = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req2 = 1'b0;
      acks += int'(ack2);
      errs += int'(err2);
      lows += int'(!vld2);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    int acks, errs, lows, first, moved;

    rstn  = 1'b0;
    adc2  = {DW'(-50), DW'(100)};
    tsel2 = 1'b0; psel2 = 1'b1; req2 = 1'b0; busy2 = 1'b0; bl2 = '0;
    adc3  = {DW'(1234), DW'(-50), DW'(100)};
    tsel3 = 2'd0; psel3 = 2'd1; req3 = 1'b0; busy3 = 1'b0; bl3 = '0;
`ifdef PNR_ROUTER_OFFSET_EN
    tofs2 = '0; pofs2 = '0; tofs3 = '0; pofs3 = '0;
`endif

    repeat (3) @(negedge clk);
    chk("rst_trig_sig", int'(trig2), 0);
    chk("rst_pnr_sig",  int'(pnr2), 0);
    chk("rst_valid",    int'(vld2), 0);
    chk("rst_trig_act", int'(tact2), 0);
    chk("rst_pnr_act",  int'(pact2), 1);
    chk("rst_ack",      int'(ack2), 0);
    chk("rst_err",      int'(err2), 0);
    chk("rst_pnr_act3", int'(pact3), 1);

    rstn = 1'b1;
    repeat (LAT + 1) @(negedge clk);
    chk("route_trig", int'(trig2), 100);
    chk("route_pnr",  int'(pnr2), -50);
    chk("route_valid", int'(vld2), 1);

    // swap with three blanked cycles
    drive2(1'b1, 1'b0, 3);
    watch2(8, acks, errs, lows);
    chk("swap_acks", acks, 1);
    chk("swap_errs", errs, 0);
    chk("swap_blank_cycles", lows, 3);
    chk("swap_trig_act", int'(tact2), 1);
    chk("swap_pnr_act", int'(pact2), 0);
    chk("swap_trig_sig", int'(trig2), -50);
    chk("swap_pnr_sig", int'(pnr2), 100);

    // deferral while busy
    busy2 = 1'b1;
    @(negedge clk);
    drive2(1'b0, 1'b1, 2);
    moved = 0; acks = 0; lows = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      req2 = 1'b0;
      if (tact2 != 1'b1 || pact2 != 1'b0) moved++;
      acks += int'(ack2);
      lows += int'(!vld2);
    end
    chk("defer_act_hold", moved, 0);
    chk("defer_no_ack", acks, 0);
    chk("defer_valid_in_pend", lows, 0);
    busy2 = 1'b0;
    first = 0; acks = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (ack2 && first == 0) first = k;
      acks += int'(ack2);
    end
    chk("defer_ack_delay", first, 3);
    chk("defer_ack_count", acks, 1);
    chk("defer_trig_act", int'(tact2), 0);
    chk("defer_pnr_act", int'(pact2), 1);

    // zero blank length: same channel on both paths, ack next cycle
    drive2(1'b1, 1'b1, 0);
    @(negedge clk);
    req2 = 1'b0;
    chk("bl0_ack", int'(ack2), 1);
    chk("bl0_valid", int'(vld2), 1);
    chk("bl0_trig_act", int'(tact2), 1);
    chk("bl0_pnr_act", int'(pact2), 1);
    @(negedge clk);
    chk("bl0_ack_once", int'(ack2), 0);
    repeat (LAT - 1) @(negedge clk);
    chk("same_ch_trig", int'(trig2), -50);
    chk("same_ch_pnr", int'(pnr2), -50);

    // second request during BLANK must be ignored
    drive2(1'b0, 1'b1, 4);
    @(negedge clk);
    req2 = 1'b0;
    first = int'(!vld2);
    @(negedge clk);
    first += int'(!vld2);
    drive2(1'b0, 1'b0, 1);
    watch2(10, acks, errs, lows);
    chk("ign_acks", acks, 1);
    chk("ign_errs", errs, 0);
    chk("ign_blank_cycles", lows + first, 4);
    chk("ign_trig_act", int'(tact2), 0);
    chk("ign_pnr_act", int'(pact2), 1);

    // rejection on the three-channel instance
    req3 = 1'b1; tsel3 = 2'd3; psel3 = 2'd0; bl3 = BW'(3);
    @(negedge clk);
    req3 = 1'b0;
    chk("rej_err", int'(err3), 1);
    chk("rej_ack", int'(ack3), 0);
    errs = 0; acks = 0; lows = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      errs += int'(err3);
      acks += int'(ack3);
      lows += int'(!vld3);
    end
    chk("rej_err_once", errs, 0);
    chk("rej_no_ack", acks, 0);
    chk("rej_no_blank", lows, 0);
    chk("rej_trig_act", int'(tact3), 0);
    chk("rej_pnr_act", int'(pact3), 1);
    req3 = 1'b1; tsel3 = 2'd0; psel3 = 2'd3;
    @(negedge clk);
    req3 = 1'b0;
    chk("rej_pnr_err", int'(err3), 1);

    req3 = 1'b1; tsel3 = 2'd2; psel3 = 2'd2; bl3 = '0;
    @(negedge clk);
    req3 = 1'b0;
    chk("ch2_ack", int'(ack3), 1);
    chk("ch2_trig_act", int'(tact3), 2);
    repeat (LAT) @(negedge clk);
    chk("ch2_trig_sig", int'(trig3), 1234);
    chk("ch2_pnr_sig", int'(pnr3), 1234);

    // reset in the middle of BLANK
    drive2(1'b1, 1'b0, 5);
    @(negedge clk);
    req2 = 1'b0;
    chk("mid_applied", int'(tact2), 1);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("mid_rst_trig_act", int'(tact2), 0);
    chk("mid_rst_pnr_act", int'(pact2), 1);
    chk("mid_rst_valid", int'(vld2), 0);
    rstn = 1'b1;
    watch2(10, acks, errs, lows);
    chk("mid_rst_no_ack", acks, 0);
    chk("mid_rst_trig_act_after", int'(tact2), 0);

`ifdef PNR_ROUTER_OFFSET_EN
    adc2  = {DW'(-50), DW'(8000)};
    tofs2 = DW'(-1000);
    pofs2 = DW'(8150);
    repeat (LAT + 1) @(negedge clk);
    chk("sat_pos", int'(trig2), 8191);
    chk("sat_neg", int'(pnr2), -8192);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
